alu_sweep_checker: RTL and testbench

//  Sequential stimulus/response partner for the 3-bit-opcode ALU. On start it drives every

---
 rtl/alu_sweep_checker_if.sv | 21 ++
 rtl/alu_sweep_checker.sv | 187 ++++++++++++++++++
 tb/tb_alu_sweep_checker.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sweep_checker_if.sv
// rtl/alu_sweep_checker_if.sv - ALU drive/response bus between the sweep checker and the ALU under test
interface alu_sweep_checker_if #(
    parameter int WIDTH = 4
);
    logic [2:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             borrow;

    modport master (
        output opcode, A, B,
        input  result, cout, borrow
    );

    modport slave (
        input  opcode, A, B,
        output result, cout, borrow
    );
endinterface

// File: rtl/alu_sweep_checker.sv
// rtl/alu_sweep_checker.sv - ALU self-test sweeper; ALU_SWEEP_EXHAUSTIVE_EN selects the all-operands sweep
module alu_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    alu_sweep_checker_if.master    alu,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_count,
    output logic [15:0]            vec_count,
    output logic [3+2*WIDTH-1:0]   fail_vec
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int WCW = (SETTLE > 2) ? $clog2(SETTLE) : 1;

    logic [2:0]       state;
    logic [WCW-1:0]   wait_cnt;
    logic [2:0]       op_idx;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic             last_vec;
    logic             accept;
    logic             advance;

    logic [WIDTH-1:0] exp_res;
    logic             exp_cout;
    logic             exp_borrow;
    logic [WIDTH:0]   sum;
    logic             mismatch;
    logic [15:0]      vec_next;

    assign busy    = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
    assign advance = (state == S_CHECK);

`ifdef ALU_SWEEP_EXHAUSTIVE_EN
    logic [WIDTH-1:0] a_idx;
    logic [WIDTH-1:0] b_idx;

    assign vec_a    = a_idx;
    assign vec_b    = b_idx;
    assign last_vec = (op_idx == 3'd7) && (&a_idx) && (&b_idx);
    assign vec_next = (vec_count == 16'hFFFF) ? vec_count : vec_count + 16'd1;

    // Walk B fastest, then A, then opcode; restart from zero on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_idx <= '0;
            a_idx  <= '0;
            b_idx  <= '0;
        end else if (accept) begin
            op_idx <= '0;
            a_idx  <= '0;
            b_idx  <= '0;
        end else if (advance) begin
            b_idx <= b_idx + 1'b1;
            if (&b_idx) begin
                a_idx <= a_idx + 1'b1;
                if (&a_idx) begin
                    op_idx <= op_idx + 3'd1;
                end
            end
        end
    end
`else
    localparam logic [WIDTH-1:0] P0_A = WIDTH'(4);
    localparam logic [WIDTH-1:0] P0_B = WIDTH'(3);
    localparam logic [WIDTH-1:0] P1_A = WIDTH'(6);
    localparam logic [WIDTH-1:0] P1_B = WIDTH'(7);

    logic pair_idx;

    assign vec_a    = pair_idx ? P1_A : P0_A;
    assign vec_b    = pair_idx ? P1_B : P0_B;
    assign last_vec = (op_idx == 3'd7) && pair_idx;
    assign vec_next = vec_count + 16'd1;

    // Walk the two operand pairs inside each opcode; restart from zero on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_idx   <= '0;
            pair_idx <= 1'b0;
        end else if (accept) begin
            op_idx   <= '0;
            pair_idx <= 1'b0;
        end else if (advance) begin
            pair_idx <= ~pair_idx;
            if (pair_idx) begin
                op_idx <= op_idx + 3'd1;
            end
        end
    end
`endif

    // Reference ALU evaluated on the operands currently held on the bus.
    always_comb begin
        exp_res    = '0;
        exp_cout   = 1'b0;
        exp_borrow = 1'b0;
        sum        = {1'b0, alu.A} + {1'b0, alu.B};
        case (alu.opcode)
            3'd0: {exp_cout, exp_res} = sum;
            3'd1: begin
                exp_res    = alu.A - alu.B;
                exp_borrow = (alu.A < alu.B);
            end
            3'd2: exp_res = alu.A & alu.B;
            3'd3: exp_res = alu.A | alu.B;
            3'd4: exp_res = alu.A ^ alu.B;
            3'd5: exp_res = ~alu.A;
            3'd6: exp_res = alu.A << 1;
            default: exp_res = alu.A >> 1;
        endcase
        mismatch = (alu.result != exp_res) || (alu.cout != exp_cout) || (alu.borrow != exp_borrow);
    end

    // Sweep sequencer: drive a vector, let the ALU settle, then score it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            alu.opcode <= '0;
            alu.A      <= '0;
            alu.B      <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_DRIVE;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        vec_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                S_DRIVE: begin
                    alu.opcode <= op_idx;
                    alu.A      <= vec_a;
                    alu.B      <= vec_b;
                    wait_cnt   <= '0;
                    state      <= (SETTLE == 1) ? S_CHECK : S_WAIT;
                end
                S_WAIT: begin
                    if (int'(wait_cnt) >= SETTLE - 2) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    vec_count <= vec_next;
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (err_count == 16'd0) begin
                            fail_vec <= {alu.opcode, alu.A, alu.B};
                        end
                    end
                    if (last_vec) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_count == 16'd0) && !mismatch;
                    end else begin
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sweep_checker.sv
// tb/tb_alu_sweep_checker.sv - directed bench for alu_sweep_checker with a fault-injectable ALU
module tb_alu_sweep_checker;
    localparam int W      = 4;
    localparam int SETTLE = 2;
`ifdef ALU_SWEEP_EXHAUSTIVE_EN
    localparam int NVEC   = 2048;
`else
    localparam int NVEC   = 16;
`endif
    localparam int LIMIT  = 20000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   err_count;
    logic [15:0]   vec_count;
    logic [3+2*W-1:0] fail_vec;

    int checks = 0;
    int errors = 0;
    int fault  = 0;

    alu_sweep_checker_if #(.WIDTH(W)) bus ();

    alu_sweep_checker #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .alu       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_count (vec_count),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            3'd0: alu_ref = {s[W-1:0], s[W], 1'b0};
            3'd1: alu_ref = {a - b, 1'b0, (a < b)};
            3'd2: alu_ref = {a & b, 2'b00};
            3'd3: alu_ref = {a | b, 2'b00};
            3'd4: alu_ref = {a ^ b, 2'b00};
            3'd5: alu_ref = {~a, 2'b00};
            3'd6: alu_ref = {a << 1, 2'b00};
            default: alu_ref = {a >> 1, 2'b00};
        endcase
    endfunction

    // ALU under test: fault 1 = ADD carry forced 0, 2 = SUB borrow stuck 0, 3 = result stuck 0
    always_comb begin
        logic [W+1:0] r;
        r = alu_ref(bus.opcode, bus.A, bus.B);
        bus.result = r[W+1:2];
        bus.cout   = r[1];
        bus.borrow = r[0];
        if (fault == 1 && bus.opcode == 3'd0) bus.cout = 1'b0;
        if (fault == 2) bus.borrow = 1'b0;
        if (fault == 3) bus.result = '0;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_vec(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (vec_count == 16'(n)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {busy, done, pass});
        end
        checks++;
        if ({err_count, vec_count, fail_vec, bus.opcode, bus.A, bus.B} !== '0) begin
            errors++;
            $display("FAIL reset_regs got err=%0d vec=%0d fv=%h op=%0d A=%0d B=%0d want all 0",
                     err_count, vec_count, fail_vec, bus.opcode, bus.A, bus.B);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_sweep();
        int cyc;
        bit ok;
        fault = 0;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy got %b want 1", busy);
        end
        @(posedge clk);
        #1;
        checks++;
`ifdef ALU_SWEEP_EXHAUSTIVE_EN
        if ({bus.opcode, bus.A, bus.B} !== {3'd0, 4'd0, 4'd0}) begin
`else
        if ({bus.opcode, bus.A, bus.B} !== {3'd0, 4'd4, 4'd3}) begin
`endif
            errors++;
            $display("FAIL first_vector got op=%0d A=%0d B=%0d", bus.opcode, bus.A, bus.B);
        end
        wait_done(cyc, ok);
        cyc++;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL clean_timeout got done=%b want 1", done);
        end
        checks++;
        if (cyc != NVEC * (SETTLE + 1)) begin
            errors++;
            $display("FAIL sweep_length got %0d want %0d", cyc, NVEC * (SETTLE + 1));
        end
        checks++;
        if ({busy, pass, err_count, vec_count, fail_vec} !== {1'b0, 1'b1, 16'd0, 16'(NVEC), 11'd0}) begin
            errors++;
            $display("FAIL clean_result got busy=%b pass=%b err=%0d vec=%0d fv=%h want 0 1 0 %0d 0",
                     busy, pass, err_count, vec_count, fail_vec, NVEC);
        end
    endtask

    task automatic test_mid_sweep_reset();
        bit ok;
        fault = 0;
        pulse_start();
        wait_vec(5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_wait got vec=%0d want 5", vec_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, err_count, vec_count, bus.opcode, bus.A, bus.B} !== '0) begin
            errors++;
            $display("FAIL midreset_async got busy=%b done=%b vec=%0d op=%0d A=%0d B=%0d want all 0",
                     busy, done, vec_count, bus.opcode, bus.A, bus.B);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, vec_count} !== '0) begin
            errors++;
            $display("FAIL midreset_idle got busy=%b done=%b vec=%0d want 0 0 0", busy, done, vec_count);
        end
    endtask

    task automatic run_fault(input int f, input string name, input logic [15:0] exp_err,
                             input logic exp_pass, input logic [10:0] exp_fv);
        int cyc;
        bit ok;
        fault = f;
        pulse_start();
        wait_done(cyc, ok);
        checks++;
        if (!ok || err_count !== exp_err) begin
            errors++;
            $display("FAIL %s_err got %0d want %0d", name, err_count, exp_err);
        end
        checks++;
        if (pass !== exp_pass || vec_count !== 16'(NVEC)) begin
            errors++;
            $display("FAIL %s_pass got pass=%b vec=%0d want %b %0d", name, pass, vec_count, exp_pass, NVEC);
        end
        checks++;
        if (fail_vec !== exp_fv) begin
            errors++;
            $display("FAIL %s_fail_vec got %h want %h", name, fail_vec, exp_fv);
        end
    endtask

    task automatic test_add_cout_fault();
`ifdef ALU_SWEEP_EXHAUSTIVE_EN
        run_fault(1, "add_cout", 16'd120, 1'b0, {3'd0, 4'd1, 4'd15});
`else
        run_fault(1, "add_cout", 16'd0, 1'b1, 11'd0);
`endif
    endtask

    task automatic test_sub_borrow_fault();
`ifdef ALU_SWEEP_EXHAUSTIVE_EN
        run_fault(2, "sub_borrow", 16'd120, 1'b0, {3'd1, 4'd0, 4'd1});
`else
        run_fault(2, "sub_borrow", 16'd1, 1'b0, {3'd1, 4'd6, 4'd7});
`endif
    endtask

    task automatic test_result_stuck();
`ifdef ALU_SWEEP_EXHAUSTIVE_EN
        int n = 0;
        logic [W+1:0] r;
        for (int op = 0; op < 8; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    r = alu_ref(3'(op), 4'(a), 4'(b));
                    if (r[W+1:2] != 0) n++;
                end
        run_fault(3, "result_stuck", 16'(n), 1'b0, {3'd0, 4'd0, 4'd1});
`else
        run_fault(3, "result_stuck", 16'd15, 1'b0, {3'd0, 4'd4, 4'd3});
`endif
    endtask

    task automatic test_start_while_busy();
        int cyc;
        bit ok;
        fault = 0;
        pulse_start();
        wait_vec(3, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, ok);
        checks++;
        if (!ok || vec_count !== 16'(NVEC) || pass !== 1'b1) begin
            errors++;
            $display("FAIL busy_start got vec=%0d pass=%b want %0d 1", vec_count, pass, NVEC);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got busy=%b done=%b want 0 1", busy, done);
        end
    endtask

    task automatic test_restart_from_done();
        int cyc;
        bit ok;
        fault = 0;
        pulse_start();
        checks++;
        if ({busy, done, pass, err_count, vec_count, fail_vec} !== {1'b1, 2'b00, 16'd0, 16'd0, 11'd0}) begin
            errors++;
            $display("FAIL restart_clear got busy=%b done=%b pass=%b err=%0d vec=%0d fv=%h want 1 0 0 0 0 0",
                     busy, done, pass, err_count, vec_count, fail_vec);
        end
        wait_done(cyc, ok);
        checks++;
        if (!ok || pass !== 1'b1 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL restart_sweep got pass=%b err=%0d want 1 0", pass, err_count);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_clean_sweep();
        test_mid_sweep_reset();
        test_add_cout_fault();
        test_sub_borrow_fault();
        test_restart_from_done();
        test_start_while_busy();
        test_result_stuck();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
